// File: rtl/alu_sequencer_pkg.sv
// Shared encodings for the ALU sequencer: ISA opcodes, ALU opcodes, opcode map and FSM states.
// Also used by the ALU and by the assembler tables, so the values here are fixed.
package alu_sequencer_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDA  = 4'h1;
    localparam logic [3:0] OP_LDB  = 4'h2;
    localparam logic [3:0] OP_MUL  = 4'h3;
    localparam logic [3:0] OP_DIV  = 4'h4;
    localparam logic [3:0] OP_SHL  = 4'h5;
    localparam logic [3:0] OP_SHR  = 4'h6;
    localparam logic [3:0] OP_ADD  = 4'h7;
    localparam logic [3:0] OP_SUB  = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [7:0] ALU_LOADA = 8'h00;
    localparam logic [7:0] ALU_MUL   = 8'h01;
    localparam logic [7:0] ALU_DIV   = 8'h02;
    localparam logic [7:0] ALU_SHL   = 8'h03;
    localparam logic [7:0] ALU_SHR   = 8'h04;
    localparam logic [7:0] ALU_ADD   = 8'h05;
    localparam logic [7:0] ALU_SUB   = 8'h06;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_OPND   = 4'd3,
        ST_LOAD   = 4'd4,
        ST_EXEC   = 4'd5,
        ST_WAIT   = 4'd6,
        ST_WB     = 4'd7,
        ST_HALT   = 4'd8
    } state_e;

    function automatic logic [7:0] alu_code(input logic [3:0] op);
        case (op)
            OP_MUL:  alu_code = ALU_MUL;
            OP_DIV:  alu_code = ALU_DIV;
            OP_SHL:  alu_code = ALU_SHL;
            OP_SHR:  alu_code = ALU_SHR;
            OP_ADD:  alu_code = ALU_ADD;
            OP_SUB:  alu_code = ALU_SUB;
            default: alu_code = ALU_LOADA;
        endcase
    endfunction

    function automatic logic is_alu_op(input logic [3:0] op);
        return op inside {OP_MUL, OP_DIV, OP_SHL, OP_SHR, OP_ADD, OP_SUB};
    endfunction

endpackage

// File: rtl/alu_sequencer_wait_timer.sv
// Counts out the ALU latency: loaded with LAT-1 during decode, counts down while enabled,
// done_o pulses in the last cycle the opcode must stay on the ALU.
module alu_seq_wait_timer #(
    parameter int unsigned LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic en_i,
    output logic done_o
);

    localparam int unsigned CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_W'(LAT - 1);
        end else if (en_i && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/alu_sequencer.sv
// Program sequencer for the 8-bit ALU: fetch/decode, operand loads, ALU issue and writeback.
// Define ALU_DIVZERO_TRAP_EN to trap DIV with B==0 into HALT and expose the div_err port.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned ALU_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        alu_inst,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    input  logic [7:0]        alu_result,
    input  logic              alu_carry,
    input  logic              alu_comp,
    output logic [7:0]        acc,
    output logic              carry_q,
    output logic              comp_q,
    output logic              busy,
    output logic              halted
`ifdef ALU_DIVZERO_TRAP_EN
    ,
    output logic              div_err
`endif
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [3:0]        ir_q, ir_d;
    logic [7:0]        a_q, a_d, b_q, b_d;
    logic              cy_q, cy_d, cmp_q, cmp_d;
    logic              rst_seen_q;
    logic              start_ok, lat_done;
    logic [3:0]        op_rd;
`ifdef ALU_DIVZERO_TRAP_EN
    logic              derr_q, derr_d;
`endif

    assign op_rd    = mem_rdata[7:4];
    // The first edge after reset release never accepts start, even if it is already high.
    assign start_ok = start && rst_seen_q;

    alu_seq_wait_timer #(.LAT(ALU_LAT)) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (state_q == ST_DECODE),
        .en_i   (state_q == ST_EXEC || state_q == ST_WAIT),
        .done_o (lat_done)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        cy_d     = cy_q;
        cmp_d    = cmp_q;
        mem_rd   = 1'b0;
        alu_inst = ALU_LOADA;
`ifdef ALU_DIVZERO_TRAP_EN
        derr_d   = derr_q;
`endif
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start_ok) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
`ifdef ALU_DIVZERO_TRAP_EN
                    derr_d  = 1'b0;
`endif
                end
            end
            ST_FETCH, ST_OPND: begin
                mem_rd  = 1'b1;
                pc_d    = pc_q + ADDR_W'(1);
                state_d = (state_q == ST_FETCH) ? ST_DECODE : ST_LOAD;
            end
            ST_DECODE: begin
                ir_d = op_rd;
                if (op_rd == OP_LDA || op_rd == OP_LDB) begin
                    state_d = ST_OPND;
                end else if (op_rd == OP_HALT) begin
                    state_d = ST_HALT;
                end else if (is_alu_op(op_rd)) begin
`ifdef ALU_DIVZERO_TRAP_EN
                    if (op_rd == OP_DIV && b_q == '0) begin
                        state_d = ST_HALT;
                        derr_d  = 1'b1;
                    end else begin
                        state_d = ST_EXEC;
                    end
`else
                    state_d = ST_EXEC;
`endif
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_LOAD: begin
                if (ir_q == OP_LDA) a_d = mem_rdata;
                else                b_d = mem_rdata;
                state_d = ST_FETCH;
            end
            ST_EXEC, ST_WAIT: begin
                alu_inst = alu_code(ir_q);
                state_d  = lat_done ? ST_WB : ST_WAIT;
            end
            ST_WB: begin
                a_d = alu_result;
                if (ir_q == OP_ADD) cy_d  = alu_carry;
                if (ir_q == OP_SUB) cmp_d = alu_comp;
                state_d = ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cy_q       <= 1'b0;
            cmp_q      <= 1'b0;
            rst_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cy_q       <= cy_d;
            cmp_q      <= cmp_d;
            rst_seen_q <= 1'b1;
        end
    end

`ifdef ALU_DIVZERO_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) derr_q <= 1'b0;
        else        derr_q <= derr_d;
    end

    assign div_err = derr_q;
`endif

    assign mem_addr = pc_q;
    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign acc      = a_q;
    assign carry_q  = cy_q;
    assign comp_q   = cmp_q;
    assign busy     = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign halted   = (state_q == ST_HALT);

endmodule
